// File: rtl/single_bit_b_ctrl.sv
// rtl/single_bit_b_ctrl.sv - bit-serial GF(2^m) multiplier sequencer around one single_bit_b_pe row
//
// single_bit_b_pe: one systolic row step, t = t_i1_j1 ^ (t_i1_m1 ? g : 0) ^ (b ? a : 0)
//   a        [m-1:0] multiplicand
//   b                current multiplier bit
//   g        [m-1:0] field polynomial without x^m
//   t_i1_j1  [m-1:0] previous partial product shifted left by one
//   t_i1_m1          previous partial product MSB (reduction trigger)
//   t        [m-1:0] new partial product
//
// single_bit_b_ctrl: accepts (a, b, g), runs m PE steps MSB-first, returns a*b mod (x^m + g)
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        operand handshake (in_ready high only in IDLE)
//   a, b, g      [m-1:0]     operands, sampled at acceptance only
//   out_valid/out_ready      result handshake (out_valid high only in DONE)
//   result       [m-1:0]     partial product register, final product while out_valid
//   busy                     high while in RUN
//   abort                    only with SINGLE_BIT_B_CTRL_ABORT_EN: drop operation in RUN/DONE
//
// Operand width m comes from the DATA_WIDTH define (defaults to 4 when not supplied).

`ifndef DATA_WIDTH
`define DATA_WIDTH 4
`endif

module single_bit_b_pe #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic         b,
    input  logic [W-1:0] g,
    input  logic [W-1:0] t_i1_j1,
    input  logic         t_i1_m1,
    output logic [W-1:0] t
);

    always_comb begin
        t = '0;
        for (int j = 0; j < W; j++) begin
            t[j] = t_i1_j1[j] ^ (t_i1_m1 & g[j]) ^ (b & a[j]);
        end
    end

endmodule

module single_bit_b_ctrl (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [`DATA_WIDTH-1:0] a,
    input  logic [`DATA_WIDTH-1:0] b,
    input  logic [`DATA_WIDTH-1:0] g,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [`DATA_WIDTH-1:0] result,
    output logic                   busy
`ifdef SINGLE_BIT_B_CTRL_ABORT_EN
    ,
    input  logic                   abort
`endif
);

    localparam int W     = `DATA_WIDTH;
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       g_reg;
    logic [W-1:0]       b_reg;
    logic [W-1:0]       t_reg;
    logic [CNT_W-1:0]   cnt;
    logic [W-1:0]       pe_t;
    logic               accept;
    logic               abort_hit;

    // Abort only matters once an operation is in flight; in IDLE it is ignored
    // so a simultaneous in_valid is still accepted.
`ifdef SINGLE_BIT_B_CTRL_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign accept = (state == IDLE) && in_valid;

    single_bit_b_pe #(
        .W (W)
    ) u_pe (
        .a       (a_reg),
        .b       (b_reg[W-1]),
        .g       (g_reg),
        .t_i1_j1 ({t_reg[W-2:0], 1'b0}),
        .t_i1_m1 (t_reg[W-1]),
        .t       (pe_t)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Always pass through IDLE before the next accept.
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (abort_hit) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            g_reg <= '0;
            b_reg <= '0;
            t_reg <= '0;
            cnt   <= '0;
        end else if (abort_hit) begin
            t_reg <= '0;
        end else if (accept) begin
            a_reg <= a;
            g_reg <= g;
            b_reg <= b;
            t_reg <= '0;
            cnt   <= CNT_W'(W - 1);
        end else if (state == RUN) begin
            t_reg <= pe_t;
            b_reg <= {b_reg[W-2:0], 1'b0};
            cnt   <= cnt - 1'b1;
        end
    end

    // All handshake outputs decode the state register only, so they are
    // registered and have no combinational path from in_valid/out_ready.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);
    assign result    = t_reg;

endmodule

// File: tb/tb_single_bit_b_ctrl.sv
// tb/tb_single_bit_b_ctrl.sv - randomized self-checking bench for single_bit_b_ctrl

`ifndef DATA_WIDTH
`define DATA_WIDTH 4
`endif

module tb_single_bit_b_ctrl;

    localparam int W = `DATA_WIDTH;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] g;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         busy;
    logic         abort_v;

    int checks;
    int errors;

    single_bit_b_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .g         (g),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
`ifdef SINGLE_BIT_B_CTRL_ABORT_EN
        ,
        .abort     (abort_v)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: full carry-less product, then polynomial long division by x^m + g.
    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [W-1:0] p);
        logic [2*W-1:0] prod;
        logic [2*W-1:0] poly;
        prod = '0;
        for (int i = 0; i < W; i++) begin
            if (y[i]) prod = prod ^ ((2*W)'(x) << i);
        end
        poly = (2*W)'({1'b1, p});
        for (int k = 2*W-2; k >= W; k--) begin
            if (prod[k]) prod = prod ^ (poly << (k - W));
        end
        return prod[W-1:0];
    endfunction

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [W-1:0] gv,
                          input int hold, input logic [W-1:0] exp_r);
        int cyc;
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        a = av; b = bv; g = gv; in_valid = 1'b1;
        @(negedge clk);
        abort_v = 1'b0;
        in_valid = 1'b0;
        cyc = 1;
        check("busy_run", busy, 1);
        check("in_ready_run", in_ready, 0);
        while (!out_valid && cyc < 4*W + 8) begin
            a = W'($urandom); b = W'($urandom); g = W'($urandom);
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("latency", cyc, W + 1);
        check("result", result, exp_r);
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid = 1'b1;
            a = W'($urandom); b = W'($urandom); g = W'($urandom);
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_result", result, exp_r);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
    endtask

    task automatic watch_no_valid(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        logic [W-1:0] ra, rb, rg;
        checks = 0; errors = 0;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; abort_v = 1'b0;
        a = '0; b = '0; g = '0;

        // Asynchronous reset between clock edges.
        #3 rst = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        #9 rst = 1'b0;

        run_op(W'(4'h2), W'(4'h8), W'(4'h3), 0, W'(4'h3));
        run_op(W'(4'h3), W'(4'h3), W'(4'h3), 0, W'(4'h5));
        run_op(W'(4'hF), W'(4'h1), W'(4'h3), 0, W'(4'hF));
        run_op(W'(4'hF), W'(4'h0), W'(4'h3), 0, W'(4'h0));
        run_op(W'(4'h0), W'(4'hB), W'(4'h3), 1, W'(4'h0));

        // Backpressure: 10 stalled cycles with an ignored in_valid.
        run_op(W'(4'h7), W'(4'h9), W'(4'h3), 10, gf_mul(W'(4'h7), W'(4'h9), W'(4'h3)));

        // Reset two cycles into RUN.
        @(negedge clk);
        a = W'(4'h5); b = W'(4'h6); g = W'(4'h3); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrun_rst_in_ready", in_ready, 1);
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_result", result, 0);
        #1 rst = 1'b0;
        watch_no_valid("midrun_rst_no_valid", 2*W + 2);
        run_op(W'(4'h2), W'(4'h8), W'(4'h3), 0, W'(4'h3));

`ifdef SINGLE_BIT_B_CTRL_ABORT_EN
        // Abort in the second RUN cycle.
        @(negedge clk);
        a = W'(4'h5); b = W'(4'h6); g = W'(4'h3); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        abort_v = 1'b1;
        @(negedge clk);
        abort_v = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_result", result, 0);
        watch_no_valid("abort_no_valid", W + 3);

        // Abort coincident with in_valid in IDLE is ignored.
        abort_v = 1'b1;
        run_op(W'(4'h2), W'(4'h8), W'(4'h3), 0, W'(4'h3));
`endif

        // Randomized operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom); rb = W'($urandom); rg = W'($urandom);
            run_op(ra, rb, rg, $urandom_range(0, 3), gf_mul(ra, rb, rg));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
